// File: rtl/sixteenbit_pkg.sv
// Shared types and default widths for the 16-bit datapath blocks.
package sixteenbit_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int ADDR_W_DEF  = 16;
    localparam int REG_W_DEF   = 4;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        LW   = 2'b01,
        SW   = 2'b10
    } mem_op_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } mem_state_t;

endpackage

// File: rtl/sixteenbit_timeout_ctr.sv
// Down-counting access timer: clear loads the window, expired flags the last allowed cycle.
module sixteenbit_timeout_ctr #(
    parameter int TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= LOAD_VAL;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    // Loaded with TIMEOUT-1 on accept, so zero is reached in the TIMEOUT-th access cycle.
    assign expired = (count == '0);

endmodule

// File: rtl/sixteenbit_mem_stage.sv
// Memory-access stage: ALU results pass to writeback, LW/SW become a bounded req/ack transaction.
//  state  | meaning
//  IDLE   | ready for a new op; NONE ops retire from here
//  ACCESS | mem_req held until mem_ack or timeout expiry
module sixteenbit_mem_stage
    import sixteenbit_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic [1:0]        ex_op,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [DATA_W-1:0] ex_wdata,
    input  logic [REG_W-1:0]  ex_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_valid,
    output logic              wb_we,
    output logic [REG_W-1:0]  wb_rd,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_err
);

    mem_state_t       state;
    logic [REG_W-1:0] rd_q;
    logic             is_mem_op;
    logic             accept_mem;
    logic             expired;

    assign ex_ready   = (state == IDLE) && !rst;
    assign is_mem_op  = (ex_op == LW) || (ex_op == SW);
    assign accept_mem = (state == IDLE) && ex_valid && is_mem_op;

    sixteenbit_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk     (clk),
        .rst     (rst),
        .clear   (accept_mem),
        .enable  ((state == ACCESS) && !mem_ack),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_q      <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            wb_valid  <= 1'b0;
            wb_we     <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            wb_err    <= 1'b0;
        end else begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid) begin
                        if (is_mem_op) begin
                            mem_req   <= 1'b1;
                            mem_we    <= (ex_op == SW);
                            mem_addr  <= ex_addr;
                            mem_wdata <= ex_wdata;
                            rd_q      <= ex_rd;
                            state     <= ACCESS;
                        end else begin
                            wb_valid <= 1'b1;
                            wb_we    <= (ex_rd != '0);
                            wb_rd    <= ex_rd;
                            wb_data  <= ex_alu_result;
                        end
                    end
                end
                ACCESS: begin
                    // Ack is tested first so an ack on the expiry cycle completes cleanly.
                    if (mem_ack) begin
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_we    <= !mem_we && (rd_q != '0);
                        wb_rd    <= rd_q;
                        wb_data  <= mem_we ? '0 : mem_rdata;
                        state    <= IDLE;
                    end else if (expired) begin
                        mem_req  <= 1'b0;
                        wb_valid <= 1'b1;
                        wb_err   <= 1'b1;
                        wb_rd    <= rd_q;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
